// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
//   state_e          : controller FSM states
//   MD_TIMEOUT_DEF   : default mul/div wait limit in cycles
//   DRAIN_CYCLES_DEF : default cycles for older instructions to retire on halt
//   REG_ADDR_W       : register-file address width
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_e;

  localparam int unsigned MD_TIMEOUT_DEF   = 64;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam int unsigned REG_ADDR_W       = 5;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
//   ID_rs1/ID_rs2, ID_int_finished          : ID-stage operands and halt decode
//   EX_rd, EX_mem_read, EX_redirect,
//   EX_md_start, md_done                    : EX-stage events and mul/div completion
//   PC_stall .. EX_MEM_flush                : stall/flush enables to pipeline registers
//   cpu_halted, md_timeout                  : status
// master drives the pipeline events, slave is the controller.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] ID_rs1;
  logic [REG_ADDR_W-1:0] ID_rs2;
  logic                  ID_int_finished;
  logic [REG_ADDR_W-1:0] EX_rd;
  logic                  EX_mem_read;
  logic                  EX_redirect;
  logic                  EX_md_start;
  logic                  md_done;

  logic PC_stall;
  logic IF_ID_stall;
  logic IF_ID_flush;
  logic ID_EX_stall;
  logic ID_EX_flush;
  logic EX_MEM_flush;
  logic cpu_halted;
  logic md_timeout;

  modport master (
    output ID_rs1, ID_rs2, ID_int_finished, EX_rd, EX_mem_read,
           EX_redirect, EX_md_start, md_done,
    input  PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
           EX_MEM_flush, cpu_halted, md_timeout
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_int_finished, EX_rd, EX_mem_read,
           EX_redirect, EX_md_start, md_done,
    output PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
           EX_MEM_flush, cpu_halted, md_timeout
  );

endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags when the load in EX writes a register that ID reads.
//   mem_read : EX instruction is a load
//   rd       : EX destination register
//   rs1, rs2 : ID source register fields (compared whether used or not)
//   hazard_c : combinational stall request
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  hazard_c
);

  // x0 is never written, so a load to x0 cannot create a dependency
  assign hazard_c = mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves load-use, redirect, mul/div and halt events
// into PC / IF-ID / ID-EX / EX-MEM stall and flush enables.
//   clk, reset : core clock, synchronous active-high reset
//   hz         : hazard_ctrl_if.slave bundle (pipeline events in, enables and status out)
// Stall/flush enables are Mealy (state + same-cycle inputs); cpu_halted and
// md_timeout come from flops.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT   = MD_TIMEOUT_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  localparam int unsigned MD_CNT_W = $clog2(MD_TIMEOUT + 1);
  localparam int unsigned DR_CNT_W = $clog2(DRAIN_CYCLES + 1);

  state_e              state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [DR_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic                timeout_q, timeout_d;
  logic                halted_q;
  logic                load_use_c;

  logic pc_stall_c, if_id_stall_c, if_id_flush_c;
  logic id_ex_stall_c, id_ex_flush_c, ex_mem_flush_c;

  load_use_detect u_load_use (
    .mem_read (hz.EX_mem_read),
    .rd       (hz.EX_rd),
    .rs1      (hz.ID_rs1),
    .rs2      (hz.ID_rs2),
    .hazard_c (load_use_c)
  );

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      md_cnt_q    <= '0;
      drain_cnt_q <= '0;
      timeout_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      timeout_q   <= timeout_d;
      halted_q    <= (state_d == HALTED);
    end
  end

  // Next state, counters and stall/flush decode
  always_comb begin
    state_d        = state_q;
    md_cnt_d       = md_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    timeout_d      = timeout_q;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;

    unique case (state_q)
      RUN: begin
        if (hz.EX_redirect) begin
          // ID holds a wrong-path instruction: its hazards and halt are moot
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (hz.EX_md_start) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_stall_c  = 1'b1;
          ex_mem_flush_c = 1'b1;
          state_d        = MD_WAIT;
          md_cnt_d       = '0;
        end else if (load_use_c) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (hz.ID_int_finished) begin
          pc_stall_c    = 1'b1;
          if_id_flush_c = 1'b1;
          state_d       = DRAIN;
          drain_cnt_d   = '0;
        end
      end

      MD_WAIT: begin
        // On md_done all enables stay low so EX/MEM captures the result
        if (hz.md_done) begin
          state_d = RUN;
        end else begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_stall_c  = 1'b1;
          ex_mem_flush_c = 1'b1;
          md_cnt_d       = md_cnt_q + MD_CNT_W'(1);
          if (md_cnt_q == MD_CNT_W'(MD_TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = RUN;
          end
        end
      end

      DRAIN: begin
        pc_stall_c    = 1'b1;
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        drain_cnt_d   = drain_cnt_q + DR_CNT_W'(1);
        if (drain_cnt_q == DR_CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = HALTED;
        end
      end

      HALTED: begin
        pc_stall_c    = 1'b1;
        if_id_stall_c = 1'b1;
        id_ex_stall_c = 1'b1;
      end

      default: state_d = RUN;
    endcase
  end

  // Everything reads as zero while reset is held, even before the clearing edge
  assign hz.PC_stall     = pc_stall_c     & ~reset;
  assign hz.IF_ID_stall  = if_id_stall_c  & ~reset;
  assign hz.IF_ID_flush  = if_id_flush_c  & ~reset;
  assign hz.ID_EX_stall  = id_ex_stall_c  & ~reset;
  assign hz.ID_EX_flush  = id_ex_flush_c  & ~reset;
  assign hz.EX_MEM_flush = ex_mem_flush_c & ~reset;
  assign hz.cpu_halted   = halted_q       & ~reset;
  assign hz.md_timeout   = timeout_q      & ~reset;

  // A redirect cannot coexist with a mul/div start in the same EX instruction
  a_no_redirect_md : assert property (@(posedge clk) disable iff (reset)
    !(hz.EX_redirect && hz.EX_md_start))
    else $error("EX_redirect and EX_md_start asserted together");

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: each driven cycle pushes its expected
// output vector to a scoreboard; a negedge monitor pops and compares.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  // Expected vector bit order:
  // {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_flush, cpu_halted, md_timeout}
  localparam logic [7:0] O_NONE  = 8'b0000_0000;
  localparam logic [7:0] O_LU    = 8'b1100_1000;
  localparam logic [7:0] O_REDIR = 8'b0010_1000;
  localparam logic [7:0] O_MD    = 8'b1101_0100;
  localparam logic [7:0] O_FIN   = 8'b1010_0000;
  localparam logic [7:0] O_DRAIN = 8'b1010_1000;
  localparam logic [7:0] O_HALT  = 8'b1101_0010;
  localparam logic [7:0] O_TO    = 8'b0000_0001;

  logic clk;
  logic reset;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .MD_TIMEOUT   (8),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_errors;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the edge and queue its expected outputs
  task automatic step(input string tag, input logic [7:0] exp, input logic rst,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic mr, input logic fin, input logic redir,
                      input logic mds, input logic mdd);
    @(posedge clk);
    #1;
    reset              = rst;
    hz.ID_rs1          = rs1;
    hz.ID_rs2          = rs2;
    hz.EX_rd           = rd;
    hz.EX_mem_read     = mr;
    hz.ID_int_finished = fin;
    hz.EX_redirect     = redir;
    hz.EX_md_start     = mds;
    hz.md_done         = mdd;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input string tag, input logic [7:0] exp);
    step(tag, exp, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: compare mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, {24'd0, hz.PC_stall, hz.IF_ID_stall, hz.IF_ID_flush, hz.ID_EX_stall,
                   hz.ID_EX_flush, hz.EX_MEM_flush, hz.cpu_halted, hz.md_timeout},
               {24'd0, e});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks           = 0;
    n_errors           = 0;
    reset              = 1'b1;
    hz.ID_rs1          = '0;
    hz.ID_rs2          = '0;
    hz.EX_rd           = '0;
    hz.EX_mem_read     = 1'b0;
    hz.ID_int_finished = 1'b0;
    hz.EX_redirect     = 1'b0;
    hz.EX_md_start     = 1'b0;
    hz.md_done         = 1'b0;

    // Reset masks every output, whatever the inputs
    step("rst_quiet", O_NONE, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst_busy",  O_NONE, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle("run_idle", O_NONE);

    // Load-use
    step("lu_rs2",     O_LU,   1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("lu_after", O_NONE);
    step("lu_rs1",     O_LU,   1'b0, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_x0",      O_NONE, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_noload",  O_NONE, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_nomatch", O_NONE, 1'b0, 5'd4, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Redirect beats load-use and halt; state remains RUN
    step("redir_all",  O_REDIR, 1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("redir_run", O_NONE);

    // Mul/div with md_done 5 cycles after start; start outranks a load-use
    step("md_start", O_MD, 1'b0, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("md_wait1", O_MD);
    step("md_wait2_lu", O_MD, 1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("md_wait3", O_MD);
    idle("md_wait4", O_MD);
    step("md_done", O_NONE, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("md_run", O_NONE);

    // Mul/div that never completes: abandoned after 8 waiting cycles
    step("to_start", O_MD, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) idle($sformatf("to_wait%0d", i), O_MD);
    idle("to_flag", O_TO);
    step("to_late_done", O_TO, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("to_run_lu", O_LU | O_TO, 1'b0, 5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset on the second MD_WAIT cycle returns to RUN and clears the sticky flag
    step("rmd_start", O_MD | O_TO, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("rmd_wait1", O_MD | O_TO);
    step("rmd_reset", O_NONE, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("rmd_run", O_NONE);
    step("rmd_run_lu", O_LU, 1'b0, 5'd0, 5'd11, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Halt: finish decode, 3 drain cycles (load-use ignored), then halted for good
    step("fin", O_FIN, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("drain0", O_DRAIN, 1'b0, 5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("drain1", O_DRAIN);
    idle("drain2", O_DRAIN);
    idle("halt0", O_HALT);
    step("halt_md", O_HALT, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("halt_redir", O_HALT, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("halt_fin", O_HALT, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle($sformatf("halt_hold%0d", i), O_HALT);

    // Only reset leaves HALTED
    step("hrst", O_NONE, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("hrst_run", O_NONE);
    step("hrst_run_lu", O_LU, 1'b0, 5'd13, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("end_idle", O_NONE);

    @(negedge clk);
    #1;
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
